// File: rtl/cgra_pkg.sv
// Shared CGRA bus geometry and TCDM defaults.
package cgra_pkg;
  localparam int MP                  = 4;
  localparam int DATA_BUS_ADD_WIDTH  = 32;
  localparam int DATA_BUS_DATA_WIDTH = 32;
  localparam int TCDM_N_BANKS        = 4;
  localparam int TCDM_BANK_WORDS     = 256;
endpackage

// File: rtl/cgra_tcdm_bank.sv
// Single-port TCDM bank: byte-enable writes, registered one-cycle reads, no reset on storage.
module cgra_tcdm_bank
  import cgra_pkg::*;
#(
  parameter int WORDS = TCDM_BANK_WORDS,
  parameter int RW    = $clog2(WORDS)
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [3:0]                     be_i,
  input  logic [RW-1:0]                  addr_i,
  input  logic [DATA_BUS_DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_BUS_DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_BUS_DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_BUS_DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++)
          if (be_i[i]) r_mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end else begin
        r_rdata <= r_mem[addr_i];
      end
    end
  end

  assign rdata_o = r_rdata;
endmodule

// File: rtl/cgra_tcdm_responder.sv
// Multi-port word-interleaved TCDM: per-bank round-robin arbitration, combinational grant,
// one-cycle response, saturating stall counter.
module cgra_tcdm_responder #(
  parameter int MP         = cgra_pkg::MP,
  parameter int N_BANKS    = cgra_pkg::TCDM_N_BANKS,
  parameter int BANK_WORDS = cgra_pkg::TCDM_BANK_WORDS
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [MP-1:0]                            tcdm_req_i,
  input  logic [cgra_pkg::DATA_BUS_ADD_WIDTH-1:0]  tcdm_add_i   [MP],
  input  logic [MP-1:0]                            tcdm_wen_i,
  input  logic [3:0]                               tcdm_be_i    [MP],
  input  logic [cgra_pkg::DATA_BUS_DATA_WIDTH-1:0] tcdm_wdata_i [MP],
  output logic [MP-1:0]                            tcdm_gnt_o,
  output logic [cgra_pkg::DATA_BUS_DATA_WIDTH-1:0] tcdm_rdata_o [MP],
  output logic [MP-1:0]                            tcdm_r_valid_o,
  input  logic                                     stall_clr_i,
  output logic [31:0]                              stall_cnt_o
);
  localparam int DW = cgra_pkg::DATA_BUS_DATA_WIDTH;
  localparam int BW = $clog2(N_BANKS);
  localparam int RW = $clog2(BANK_WORDS);
  localparam int PW = $clog2(MP);

  logic [BW-1:0]      w_bank   [MP];
  logic [RW-1:0]      w_row    [MP];
  logic [PW-1:0]      r_ptr    [N_BANKS];
  logic [PW-1:0]      w_win    [N_BANKS];
  logic [N_BANKS-1:0] w_en;
  logic [N_BANKS-1:0] w_we;
  logic [3:0]         w_be     [N_BANKS];
  logic [RW-1:0]      w_brow   [N_BANKS];
  logic [DW-1:0]      w_bwdata [N_BANKS];
  logic [DW-1:0]      w_brdata [N_BANKS];
  logic [MP-1:0]      r_valid;
  logic [MP-1:0]      r_rd;
  logic [BW-1:0]      r_sel    [MP];
  logic [31:0]        r_stall_cnt;
  logic               w_found;
  logic [PW-1:0]      w_pi;
  logic               w_stall;

  // Upper address bits beyond bank+row are dropped, so the memory aliases.
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      w_bank[p] = tcdm_add_i[p][2 +: BW];
      w_row[p]  = tcdm_add_i[p][2+BW +: RW];
    end
  end

  always_comb begin
    tcdm_gnt_o = '0;
    w_en       = '0;
    w_found    = 1'b0;
    w_pi       = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      w_win[b] = '0;
      w_found  = 1'b0;
      for (int k = 0; k < MP; k++) begin
        w_pi = PW'((int'(r_ptr[b]) + k) % MP);
        if (!w_found && tcdm_req_i[w_pi] && (w_bank[w_pi] == BW'(b))) begin
          w_found  = 1'b1;
          w_win[b] = w_pi;
        end
      end
      w_en[b] = w_found && rst_ni;
      if (w_en[b]) tcdm_gnt_o[w_win[b]] = 1'b1;
    end
  end

  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      w_we[b]     = tcdm_wen_i[w_win[b]];
      w_be[b]     = tcdm_be_i[w_win[b]];
      w_brow[b]   = w_row[w_win[b]];
      w_bwdata[b] = tcdm_wdata_i[w_win[b]];
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    cgra_tcdm_bank #(.WORDS(BANK_WORDS)) u_bank (
      .clk_i   (clk_i),
      .en_i    (w_en[b]),
      .we_i    (w_we[b]),
      .be_i    (w_be[b]),
      .addr_i  (w_brow[b]),
      .wdata_i (w_bwdata[b]),
      .rdata_o (w_brdata[b])
    );
  end

  assign w_stall = |(tcdm_req_i & ~tcdm_gnt_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid     <= '0;
      r_rd        <= '0;
      r_stall_cnt <= '0;
      for (int p = 0; p < MP; p++) r_sel[p] <= '0;
      for (int b = 0; b < N_BANKS; b++) r_ptr[b] <= '0;
    end else begin
      r_valid <= tcdm_gnt_o;
      r_rd    <= tcdm_gnt_o & ~tcdm_wen_i;
      for (int p = 0; p < MP; p++) r_sel[p] <= w_bank[p];
      for (int b = 0; b < N_BANKS; b++)
        if (w_en[b]) r_ptr[b] <= PW'((int'(w_win[b]) + 1) % MP);
      if (stall_clr_i)                              r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != '1))      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Write responses and idle ports return zero data.
  always_comb begin
    for (int p = 0; p < MP; p++)
      tcdm_rdata_o[p] = r_rd[p] ? w_brdata[r_sel[p]] : '0;
  end

  assign tcdm_r_valid_o = r_valid;
  assign stall_cnt_o    = r_stall_cnt;
endmodule

// File: tb/tb_cgra_tcdm_responder.sv
// Directed bench for cgra_tcdm_responder: reset, single access, byte enables, conflicts,
// parallel access, back-to-back/aliasing and reset during an access.
module tb_cgra_tcdm_responder;
  localparam int MP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req, wen, gnt, rv;
  logic [31:0] add [MP];
  logic [3:0]  be  [MP];
  logic [31:0] wd  [MP];
  logic [31:0] rd  [MP];
  logic        clr;
  logic [31:0] cnt;
  int          pass_cnt = 0;
  int          total = 0;

  always #5 clk = ~clk;

  cgra_tcdm_responder dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tcdm_req_i     (req),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_wdata_i   (wd),
    .tcdm_gnt_o     (gnt),
    .tcdm_rdata_o   (rd),
    .tcdm_r_valid_o (rv),
    .stall_clr_i    (clr),
    .stall_cnt_o    (cnt)
  );

  task automatic idle();
    req = '0;
    wen = '0;
    for (int p = 0; p < MP; p++) begin
      add[p] = '0; be[p] = '0; wd[p] = '0;
    end
  endtask

  task automatic drv(input int p, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1; wen[p] = w; add[p] = a; be[p] = b; wd[p] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; idle();
    drv(0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", gnt); else pass_cnt++;
    total++; if (rv !== 4'b0000) $display("FAIL rst_rvalid: got %b want 0000", rv); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1; idle();
    @(negedge clk);
    total++; if (rv !== 4'b0000) $display("FAIL idle_rvalid: got %b want 0000", rv); else pass_cnt++;
    total++; if (rd[0] !== 32'h0 || rd[3] !== 32'h0) $display("FAIL idle_rdata: got %h/%h want 0", rd[0], rd[3]); else pass_cnt++;
    total++; if (cnt !== 32'h0) $display("FAIL idle_stall: got %0d want 0", cnt); else pass_cnt++;
  endtask

  task automatic test_single();
    drv(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    total++; if (gnt !== 4'b0001) $display("FAIL single_wr_gnt: got %b want 0001", gnt); else pass_cnt++;
    @(negedge clk);
    total++; if (rv !== 4'b0001) $display("FAIL single_wr_rvalid: got %b want 0001", rv); else pass_cnt++;
    total++; if (rd[0] !== 32'h0) $display("FAIL single_wr_rdata: got %h want 0", rd[0]); else pass_cnt++;
    idle(); drv(0, 1'b0, 32'h10, 4'h0, 32'h0);
    #1;
    total++; if (gnt !== 4'b0001) $display("FAIL single_rd_gnt: got %b want 0001", gnt); else pass_cnt++;
    @(negedge clk);
    total++; if (rv !== 4'b0001) $display("FAIL single_rd_rvalid: got %b want 0001", rv); else pass_cnt++;
    total++; if (rd[0] !== 32'hDEADBEEF) $display("FAIL single_rd_rdata: got %h want deadbeef", rd[0]); else pass_cnt++;
    idle();
    @(negedge clk);
    total++; if (rv !== 4'b0000 || rd[0] !== 32'h0) $display("FAIL single_quiet: rv %b rdata %h want 0000/0", rv, rd[0]); else pass_cnt++;
    total++; if (cnt !== 32'h0) $display("FAIL single_stall: got %0d want 0", cnt); else pass_cnt++;
  endtask

  task automatic test_byte_en();
    drv(2, 1'b1, 32'h20, 4'hF, 32'h11223344);
    #1;
    total++; if (gnt !== 4'b0100) $display("FAIL be_gnt: got %b want 0100", gnt); else pass_cnt++;
    @(negedge clk);
    idle(); drv(2, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    @(negedge clk);
    idle(); drv(2, 1'b0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (rv !== 4'b0100) $display("FAIL be_rvalid: got %b want 0100", rv); else pass_cnt++;
    total++; if (rd[2] !== 32'h11BB33DD) $display("FAIL be_rdata: got %h want 11bb33dd", rd[2]); else pass_cnt++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_conflict();
    logic [3:0] exp_g;
    logic [3:0] prev_g;
    do_reset();
    for (int p = 0; p < MP; p++) drv(p, 1'b0, 32'h0, 4'h0, 32'h0);
    prev_g = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_g = 4'b0001 << (i % 4);
      total++; if (gnt !== exp_g) $display("FAIL rr_gnt%0d: got %b want %b", i, gnt, exp_g); else pass_cnt++;
      total++; if (cnt !== 32'(i)) $display("FAIL rr_stall%0d: got %0d want %0d", i, cnt, i); else pass_cnt++;
      if (i > 0) begin
        total++; if (rv !== prev_g) $display("FAIL rr_rvalid%0d: got %b want %b", i, rv, prev_g); else pass_cnt++;
      end
      prev_g = exp_g;
      @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk);
    total++; if (cnt !== 32'h0) $display("FAIL clr_prio: got %0d want 0", cnt); else pass_cnt++;
    clr = 1'b0; idle();
    @(negedge clk);
    total++; if (cnt !== 32'h0) $display("FAIL clr_hold: got %0d want 0", cnt); else pass_cnt++;
  endtask

  task automatic test_parallel();
    logic [31:0] saved;
    saved = cnt;
    for (int p = 0; p < MP; p++) drv(p, 1'b1, 32'(p * 4), 4'hF, 32'hCAFE0000 | 32'(p));
    #1;
    total++; if (gnt !== 4'b1111) $display("FAIL par_wr_gnt: got %b want 1111", gnt); else pass_cnt++;
    @(negedge clk);
    total++; if (rv !== 4'b1111) $display("FAIL par_wr_rvalid: got %b want 1111", rv); else pass_cnt++;
    idle();
    for (int p = 0; p < MP; p++) drv(p, 1'b0, 32'(p * 4), 4'h0, 32'h0);
    #1;
    total++; if (gnt !== 4'b1111) $display("FAIL par_rd_gnt: got %b want 1111", gnt); else pass_cnt++;
    @(negedge clk);
    total++; if (rv !== 4'b1111) $display("FAIL par_rd_rvalid: got %b want 1111", rv); else pass_cnt++;
    for (int p = 0; p < MP; p++) begin
      total++;
      if (rd[p] !== (32'hCAFE0000 | 32'(p))) $display("FAIL par_rdata%0d: got %h want %h", p, rd[p], 32'hCAFE0000 | 32'(p));
      else pass_cnt++;
    end
    total++; if (cnt !== saved) $display("FAIL par_stall: got %0d want %0d", cnt, saved); else pass_cnt++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drv(1, 1'b1, 32'h40, 4'hF, 32'h12345678);
    #1;
    total++; if (gnt !== 4'b0010) $display("FAIL b2b_gnt: got %b want 0010", gnt); else pass_cnt++;
    @(negedge clk);
    total++; if (rv !== 4'b0010 || rd[1] !== 32'h0) $display("FAIL b2b_wr_resp: rv %b rdata %h want 0010/0", rv, rd[1]); else pass_cnt++;
    idle(); drv(1, 1'b0, 32'h40, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (rv !== 4'b0010 || rd[1] !== 32'h12345678) $display("FAIL b2b_rd_resp: rv %b rdata %h want 0010/12345678", rv, rd[1]); else pass_cnt++;
    idle(); drv(1, 1'b0, 32'h1040, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (rd[1] !== 32'h12345678) $display("FAIL alias_rdata: got %h want 12345678", rd[1]); else pass_cnt++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drv(0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    total++; if (gnt !== 4'b0001) $display("FAIL mid_gnt: got %b want 0001", gnt); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) $display("FAIL mid_rst_gnt: got %b want 0000", gnt); else pass_cnt++;
    @(negedge clk);
    total++; if (rv !== 4'b0000 || rd[0] !== 32'h0) $display("FAIL mid_dropped: rv %b rdata %h want 0000/0", rv, rd[0]); else pass_cnt++;
    rst_n = 1'b1; idle();
    drv(1, 1'b0, 32'h0, 4'h0, 32'h0);
    drv(3, 1'b0, 32'h10, 4'h0, 32'h0);
    #1;
    total++; if (gnt !== 4'b0010) $display("FAIL mid_ptr0: got %b want 0010", gnt); else pass_cnt++;
    @(negedge clk);
    total++; if (rv !== 4'b0010 || rd[1] !== 32'hCAFE0000) $display("FAIL mid_resp: rv %b rdata %h want 0010/cafe0000", rv, rd[1]); else pass_cnt++;
    idle();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_byte_en();
    test_conflict();
    test_parallel();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/cgra_tcdm_responder.md
CGRA_TCDM_RESPONDER -- requirements
Module: cgra_tcdm_responder

Interface
REQ-001 SHALL have parameter MP, default cgra_pkg MP, the number of master ports served.
REQ-002 SHALL have parameter N_BANKS, default 4 (power of two), the number of word-interleaved banks.
REQ-003 SHALL have parameter BANK_WORDS, default 256 (power of two), the depth of each bank in 32-bit words.
REQ-004 SHALL have ports, listed as name, direction, width, meaning:
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: asynchronous active-low reset.
- tcdm_req_i, in, MP: per-port request.
- tcdm_add_i, in, DATA_BUS_ADD_WIDTH x MP (unpacked [0:MP-1]): byte address.
- tcdm_wen_i, in, MP: 1 = write, 0 = read.
- tcdm_be_i, in, 4 x MP (unpacked): byte enables, writes only.
- tcdm_wdata_i, in, DATA_BUS_DATA_WIDTH x MP (unpacked): write data.
- tcdm_gnt_o, out, MP: per-port grant.
- tcdm_rdata_o, out, DATA_BUS_DATA_WIDTH x MP (unpacked): response data.
- tcdm_r_valid_o, out, MP: response valid.
- stall_clr_i, in, 1: synchronous clear of the stall counter.
- stall_cnt_o, out, 32: saturating conflict-stall counter.

Function
REQ-005 SHALL decode each address as: bits[1:0] ignored; bank = bits[2+log2(N_BANKS)-1:2]; row = the next log2(BANK_WORDS) bits; higher bits ignored (aliasing).
REQ-006 SHALL arbitrate each bank independently and grant at most one port per bank per cycle.
REQ-007 SHALL make the grant combinational: tcdm_gnt_o[p] is asserted in the same cycle as tcdm_req_i[p] when port p wins its bank.
REQ-008 SHALL grant a port only while that port's request is high.
REQ-009 SHALL use round-robin arbitration per bank: the highest-priority port is the bank pointer; scanning goes upward in index order and wraps from MP-1 to 0.
REQ-010 SHALL update a bank's pointer only when that bank grants, setting it to (winner+1) mod MP; an idle bank keeps its pointer.
REQ-011 SHALL write a granted write at the clock edge, only the bytes whose tcdm_be_i bit is set.
REQ-012 SHALL read a granted read at the clock edge (one-cycle latency).
REQ-013 SHALL assert tcdm_r_valid_o[p] for exactly one cycle, the cycle after every grant to p (reads and writes).
REQ-014 SHALL drive tcdm_rdata_o[p] with the bank word for reads and 0 for writes while r_valid is high, and 0 whenever r_valid is low.
REQ-015 SHALL have no backpressure on responses: a port granted on consecutive cycles receives responses on consecutive cycles.
REQ-016 SHALL return the newly written data when a read follows a write to the same word in the next cycle; no bypass is needed because writes and reads are one grant apart.
REQ-017 SHALL hold a request that is not granted without penalty; the master keeps req, add, wen, be and wdata stable until granted.
REQ-018 SHALL increment stall_cnt_o by 1 in each cycle in which at least one port has req=1 and gnt=0.
REQ-019 SHALL saturate stall_cnt_o at 32'hFFFF_FFFF.
REQ-020 SHALL give stall_clr_i priority over increment, so stall_cnt_o reads 0 on the next cycle.
REQ-021 SHALL provide throughput of N_BANKS accesses per cycle when all ports hit distinct banks.

Reset
REQ-022 SHALL, on reset, drive tcdm_r_valid_o=0, tcdm_rdata_o=0, stall_cnt_o=0, and set every bank pointer to 0.
REQ-023 SHALL take reset asynchronously on assertion and release it synchronously with clk_i.
REQ-024 SHALL, on reset during an access, drop the pending response (no r_valid afterwards).
REQ-025 SHALL NOT reset memory contents, which are undefined after reset.
REQ-026 SHALL keep tcdm_gnt_o at 0 while in reset.

Structure
REQ-027 SHALL take MP, DATA_BUS_ADD_WIDTH and DATA_BUS_DATA_WIDTH from cgra_pkg.
REQ-028 SHALL add TCDM_N_BANKS and TCDM_BANK_WORDS as defaults in cgra_pkg.
REQ-029 SHALL instantiate one sub-module per bank, cgra_tcdm_bank: a single-port, byte-enable, one-cycle-read storage array.
REQ-030 SHALL keep arbitration, response routing and the stall counter in the top module.

Verification
REQ-031 Reset then idle SHALL give all gnt=0, r_valid=0, rdata=0 and stall_cnt=0.
REQ-032 Single access SHALL work: port 0 writes 0xDEADBEEF to 0x0000_0010 with be=4'hF, gnt is seen the same cycle, r_valid the next cycle with rdata=0; port 0 then reads 0x10 and gets rdata=0xDEADBEEF one cycle after gnt.
REQ-033 Byte enables SHALL apply: write 0x11223344 be=4'hF, then 0xAABBCCDD be=4'b0101, then read; the read returns 0x11BB33DD.
REQ-034 Conflict SHALL resolve round-robin: all 4 ports read address 0x0 continuously from reset; grants go to port 0,1,2,3,0 on successive cycles; stall_cnt increments every cycle; stall_clr_i returns it to 0.
REQ-035 Parallel access SHALL not stall: ports 0..3 read 0x0, 0x4, 0x8 and 0xC in the same cycle; all four are granted that cycle; four r_valids come next cycle; stall_cnt is unchanged.
REQ-036 Reset mid-access SHALL drop the response: assert rst_ni=0 in the cycle after a granted read; no r_valid is seen; after release, a new request is served from port-0 priority.
